pc_stack_unit: RTL and testbench

- Parametrised successor to the single-bank program-counter register file.
- Holds a DEPTH-entry stack of PC_WIDTH program counters and a current-level pointer.
- Executes one encoded PC operation per cycle: increment, absolute jump, signed relative branch, call (push) and return (pop).
- Sticky error reporting with an explicit clear, and an optional halt-on-error mode. It sits between the control unit/decoder and the instruction-memory address port.

---
 rtl/pc_stack_unit.sv | 142 ++++++++++++++
 tb/tb_pc_stack_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program-counter stack: DEPTH levels of PC_WIDTH counters with one encoded PC
// operation per cycle (inc/jump/branch/call/ret), plus sticky error reporting.
module pc_stack_unit #(
  parameter int                  PC_WIDTH     = 9,
  parameter int                  DEPTH        = 8,
  parameter int                  OFF_WIDTH    = 9,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit                  HALT_ON_ERR  = 1'b0,
  localparam int                 LVL_W        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           op,
  input  logic [PC_WIDTH-1:0]  target,
  input  logic [OFF_WIDTH-1:0] offset,
  input  logic                 err_clr,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic [LVL_W-1:0]     lvl,
  output logic                 full,
  output logic                 empty,
  output logic                 err,
  output logic [1:0]           err_code
);

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_INC    = 3'd1,
    OP_JUMP   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_OVER  = 2'd1,
    ERR_UNDER = 2'd2,
    ERR_RSV   = 2'd3
  } err_e;

  logic [PC_WIDTH-1:0] bank_q [DEPTH];
  logic [LVL_W-1:0]    lvl_q, lvl_d, lvl_inc;
  logic                err_q, err_d;
  err_e                err_code_q, err_code_d;

  logic [PC_WIDTH-1:0] cur_pc, cur_d;
  logic                cur_wr, push, halted, new_err;
  err_e                new_code;

  assign cur_pc   = bank_q[lvl_q];
  assign lvl_inc  = lvl_q + LVL_W'(1);
  assign halted   = HALT_ON_ERR && err_q;

  assign pc_out   = cur_pc;
  assign lvl      = lvl_q;
  assign full     = (lvl_q == LVL_W'(DEPTH - 1));
  assign empty    = (lvl_q == '0);
  assign err      = err_q;
  assign err_code = err_code_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cur_wr     = 1'b0;
    cur_d      = cur_pc;
    push       = 1'b0;
    lvl_d      = lvl_q;
    new_err    = 1'b0;
    new_code   = ERR_NONE;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (!halted) begin
      case (op_e'(op))
        OP_INC: begin
          cur_wr = 1'b1;
          cur_d  = cur_pc + PC_WIDTH'(1);
        end
        OP_JUMP: begin
          cur_wr = 1'b1;
          cur_d  = target;
        end
        OP_BRANCH: begin
          cur_wr = 1'b1;
          cur_d  = cur_pc + PC_WIDTH'($signed(offset));
        end
        OP_CALL: begin
          if (full) begin
            new_err  = 1'b1;
            new_code = ERR_OVER;
          end else begin
            cur_wr = 1'b1;
            cur_d  = cur_pc + PC_WIDTH'(1);
            push   = 1'b1;
            lvl_d  = lvl_inc;
          end
        end
        OP_RET: begin
          if (empty) begin
            new_err  = 1'b1;
            new_code = ERR_UNDER;
          end else begin
            lvl_d = lvl_q - LVL_W'(1);
          end
        end
        OP_RSV6, OP_RSV7: begin
          new_err  = 1'b1;
          new_code = ERR_RSV;
        end
        default: ;
      endcase
    end

    // The first error since the last clear is kept; a clear coinciding with a new error loses.
    if (new_err) begin
      err_d      = 1'b1;
      err_code_d = (err_q && !err_clr) ? err_code_q : new_code;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stack storage is reset too, since every level must read RESET_VECTOR afterwards.
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= RESET_VECTOR;
      lvl_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (cur_wr) bank_q[lvl_q]   <= cur_d;
      if (push)   bank_q[lvl_inc] <= target;
      lvl_q      <= lvl_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: one default instance and one with halt-on-error.
module tb_pc_stack_unit;

  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, JUMP = 3'd2, BRANCH = 3'd3,
                         CALL = 3'd4, RET = 3'd5, RSV7 = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic [2:0] op = NOP, h_op = NOP;
  logic [8:0] target = '0, h_target = '0;
  logic [8:0] offset = '0, h_offset = '0;
  logic       err_clr = 1'b0, h_err_clr = 1'b0;

  logic [8:0] pc_out, h_pc_out;
  logic [2:0] lvl, h_lvl;
  logic       full, empty, err, h_full, h_empty, h_err;
  logic [1:0] err_code, h_err_code;

  always #5 clk = ~clk;

  pc_stack_unit u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .target(target), .offset(offset),
    .err_clr(err_clr), .pc_out(pc_out), .lvl(lvl), .full(full), .empty(empty),
    .err(err), .err_code(err_code)
  );

  pc_stack_unit #(.HALT_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_n), .op(h_op), .target(h_target), .offset(h_offset),
    .err_clr(h_err_clr), .pc_out(h_pc_out), .lvl(h_lvl), .full(h_full),
    .empty(h_empty), .err(h_err), .err_code(h_err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [8:0] t, input logic [8:0] f);
    op = o; target = t; offset = f;
  endtask

  task automatic check_main(input string tag, input logic [8:0] pc, input logic [2:0] lv,
                            input logic e, input logic [1:0] code);
    check({tag, " pc"}, pc_out, pc);
    check({tag, " lvl"}, lvl, lv);
    check({tag, " err"}, err, e);
    check({tag, " code"}, err_code, code);
  endtask

  initial begin
    // Reset
    #12;
    check_main("reset", 9'h000, 3'd0, 1'b0, 2'd0);
    check("reset empty", empty, 1'b1);
    check("reset full", full, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Three increments
    drive(INC, 9'h0, 9'h0);
    tick(); check_main("inc1", 9'h001, 3'd0, 1'b0, 2'd0);
    tick(); check_main("inc2", 9'h002, 3'd0, 1'b0, 2'd0);
    tick(); check_main("inc3", 9'h003, 3'd0, 1'b0, 2'd0);
    check("inc3 empty", empty, 1'b1);

    // Jump, wrap on increment, branches
    drive(JUMP, 9'h1FF, 9'h0);   tick(); check("jump 1ff", pc_out, 9'h1FF);
    drive(INC, 9'h0, 9'h0);      tick(); check("inc wrap", pc_out, 9'h000);
    drive(BRANCH, 9'h0, 9'h1FE); tick(); check("branch -2", pc_out, 9'h1FE);
    drive(JUMP, 9'h003, 9'h0);   tick(); check("jump 3", pc_out, 9'h003);
    drive(BRANCH, 9'h0, 9'h1FB); tick(); check("branch -5", pc_out, 9'h1FE);
    drive(BRANCH, 9'h0, 9'h010); tick(); check("branch +16 wrap", pc_out, 9'h00E);

    // Call / inc / return
    drive(JUMP, 9'h010, 9'h0);   tick(); check("jump 10", pc_out, 9'h010);
    drive(CALL, 9'h100, 9'h0);   tick(); check_main("call", 9'h100, 3'd1, 1'b0, 2'd0);
    check("call empty", empty, 1'b0);
    drive(INC, 9'h0, 9'h0);      tick(); check_main("call inc", 9'h101, 3'd1, 1'b0, 2'd0);
    drive(RET, 9'h0, 9'h0);      tick(); check_main("ret", 9'h011, 3'd0, 1'b0, 2'd0);

    // Fill the stack: call i moves lvl i -> i+1 with target 0x20+i
    for (int i = 0; i < 7; i++) begin
      drive(CALL, 9'(9'h020 + i), 9'h0);
      tick();
      check_main($sformatf("push%0d", i), 9'(9'h020 + i), 3'(i + 1), 1'b0, 2'd0);
    end
    check("stack full", full, 1'b1);
    drive(CALL, 9'h055, 9'h0);   tick(); check_main("overflow", 9'h026, 3'd7, 1'b1, 2'd1);
    check("overflow full", full, 1'b1);

    // Unwind: saved return address of lvl 0 is 0x012, of lvl j>=1 is 0x20+j
    for (int k = 7; k >= 1; k--) begin
      drive(RET, 9'h0, 9'h0);
      tick();
      check_main($sformatf("pop%0d", k), (k == 1) ? 9'h012 : 9'(9'h020 + k - 1),
                 3'(k - 1), 1'b1, 2'd1);
    end
    check("unwound empty", empty, 1'b1);
    drive(RET, 9'h0, 9'h0);      tick(); check_main("sticky code", 9'h012, 3'd0, 1'b1, 2'd1);

    // Clear, reserved op, clear racing a new underflow
    drive(NOP, 9'h0, 9'h0); err_clr = 1'b1;
    tick(); check_main("clear", 9'h012, 3'd0, 1'b0, 2'd0);
    err_clr = 1'b0;
    drive(RSV7, 9'h0, 9'h0);     tick(); check_main("reserved op", 9'h012, 3'd0, 1'b1, 2'd3);
    drive(RET, 9'h0, 9'h0); err_clr = 1'b1;
    tick(); check_main("clr vs underflow", 9'h012, 3'd0, 1'b1, 2'd2);
    drive(NOP, 9'h0, 9'h0);
    tick(); check_main("clear2", 9'h012, 3'd0, 1'b0, 2'd0);
    err_clr = 1'b0;

    // Halt-on-error instance
    h_op = INC;  tick(); check("halt inc", h_pc_out, 9'h001);
    h_op = RET;  tick();
    check("halt underflow err", h_err, 1'b1);
    check("halt underflow code", h_err_code, 2'd2);
    h_op = INC;  tick(); check("halted inc pc", h_pc_out, 9'h001);
    check("halted inc err", h_err, 1'b1);
    h_err_clr = 1'b1;
    tick();
    check("halt clr err", h_err, 1'b0);
    check("halt clr code", h_err_code, 2'd0);
    check("halt clr inc ignored", h_pc_out, 9'h001);
    h_err_clr = 1'b0;
    tick(); check("halt resume inc", h_pc_out, 9'h002);
    h_op = NOP;

    // Asynchronous reset in the middle of a pending CALL, with err set beforehand
    drive(RSV7, 9'h0, 9'h0);     tick(); check("pre-reset err", err, 1'b1);
    drive(JUMP, 9'h040, 9'h0);   tick(); check("pre-reset jump", pc_out, 9'h040);
    drive(CALL, 9'h077, 9'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_main("async reset", 9'h000, 3'd0, 1'b0, 2'd0);
    check("async reset empty", empty, 1'b1);
    check("async reset halt pc", h_pc_out, 9'h000);
    tick();
    check_main("reset held", 9'h000, 3'd0, 1'b0, 2'd0);
    drive(NOP, 9'h0, 9'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); check_main("after reset", 9'h000, 3'd0, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
